// File: rtl/fsm_stim_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fsm_stim_pkg
// Shared types and width helpers for the FSM stimulus arbiter family.
//   state_t   : arbiter sequencing states (2 bits)
//   idx_w()   : index width for a range of n values (at least 1 bit)
//   GAP_W     : width of the inter-frame gap counter (GAP up to 15)
// ---------------------------------------------------------------------------
package fsm_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRST  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Width needed to hold an index 0..n-1; a single requester or a
    // single-bit frame still gets a 1-bit field.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int GAP_W = 4;

endpackage

// File: rtl/fsm_stim_arbiter_if.sv
// ---------------------------------------------------------------------------
// fsm_stim_arbiter_if
// Bundle between stimulus sources and the arbiter.
//   req     : per-requester frame request (level, held until ack)
//   data    : frames, requester k on bits [k*W +: W]
//   ack     : one-hot grant pulse
//   fsm_rst : reset into the downstream FSM
//   bit_o   : serial bit into the downstream FSM
//   bit_vld : bit_o carries a frame bit
//   owner   : current / last granted requester
//   busy    : arbiter not idle
//   done    : pulse after the last bit of a frame
// master = stimulus side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface fsm_stim_arbiter_if
    import fsm_stim_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = 8
);
    localparam int OWN_W = idx_w(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] data;
    logic [N_REQ-1:0]   ack;
    logic               fsm_rst;
    logic               bit_o;
    logic               bit_vld;
    logic [OWN_W-1:0]   owner;
    logic               busy;
    logic               done;

    modport master (
        output req, data,
        input  ack, fsm_rst, bit_o, bit_vld, owner, busy, done
    );

    modport slave (
        input  req, data,
        output ack, fsm_rst, bit_o, bit_vld, owner, busy, done
    );

endinterface

// File: rtl/fsm_stim_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: first set request at or after i_ptr,
// wrapping modulo N_REQ.
//   i_req   : request vector
//   i_ptr   : highest-priority index this round
//   o_valid : some request is set
//   o_idx   : index of the winning request (0 when none)
// ---------------------------------------------------------------------------
module rr_pick
    import fsm_stim_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int OWN_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [OWN_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [OWN_W-1:0] o_idx
);

    int w_pos;

    // Scan from the farthest offset down so the nearest set request wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_pos   = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            w_pos = (int'(i_ptr) + off) % N_REQ;
            if (i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = w_pos[OWN_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fsm_stim_arbiter.sv
// ---------------------------------------------------------------------------
// fsm_stim_arbiter
// Round-robin sharing of a downstream FSM's serial input among N_REQ
// requesters: grant, pulse the FSM reset, shift the frame out MSB-first.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of fsm_stim_arbiter_if (req/data in, rest out)
// Outputs are registered from the state held during the previous cycle,
// so each state's effect appears one cycle after the state is entered.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | arbitrate; on a win load frame, ack winner, advance ptr
//   ST_FRST  | one cycle of reset into the downstream FSM
//   ST_SHIFT | W cycles presenting shift-register MSB as a frame bit
//   ST_GAP   | completion cycle (done) followed by GAP idle cycles
// ---------------------------------------------------------------------------
module fsm_stim_arbiter
    import fsm_stim_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = 8,
    parameter int GAP   = 1
) (
    input logic               clk,
    input logic               rst_n,
    fsm_stim_arbiter_if.slave bus
);

    localparam int OWN_W = idx_w(N_REQ);
    localparam int CNT_W = idx_w(W);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OWN_W-1:0]   r_ptr;
    logic [OWN_W-1:0]   r_owner;
    logic [W-1:0]       r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;

    logic               w_pick_vld;
    logic [OWN_W-1:0]   w_pick_idx;
    logic               w_last_bit;
    logic               w_gap_tc;

    logic [N_REQ-1:0]   r_ack,     w_ack;
    logic               r_fsm_rst, w_fsm_rst;
    logic               r_bit_o,   w_bit_o;
    logic               r_bit_vld, w_bit_vld;
    logic               r_busy,    w_busy;
    logic               r_done,    w_done;

    rr_pick #(.N_REQ(N_REQ), .OWN_W(OWN_W)) u_rr_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    assign w_last_bit = (r_bit_cnt == CNT_W'(W - 1));
    assign w_gap_tc   = (r_gap_cnt == '0);

    // State register and datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_shift   <= bus.data[int'(w_pick_idx)*W +: W];
                        r_owner   <= w_pick_idx;
                        r_ptr     <= (w_pick_idx == OWN_W'(N_REQ - 1)) ? '0
                                                                       : w_pick_idx + OWN_W'(1);
                        r_bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_shift <= {r_shift[W-2:0], 1'b0};
                    if (w_last_bit) begin
                        r_bit_cnt <= '0;
                        r_gap_cnt <= GAP_W'(GAP);
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (!w_gap_tc) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_vld) w_state_nxt = ST_FRST;
            ST_FRST:  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last_bit) w_state_nxt = ST_GAP;
            ST_GAP:   if (w_gap_tc)   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; the gap counter still holds its load value in the
    // first ST_GAP cycle, which marks the completion cycle.
    always_comb begin
        w_ack     = '0;
        w_fsm_rst = 1'b0;
        w_bit_o   = 1'b0;
        w_bit_vld = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_pick_vld) w_ack = N_REQ'(1) << w_pick_idx;
            ST_FRST: begin
                w_fsm_rst = 1'b1;
                w_busy    = 1'b1;
            end
            ST_SHIFT: begin
                w_bit_vld = 1'b1;
                w_bit_o   = r_shift[W-1];
                w_busy    = 1'b1;
            end
            ST_GAP: begin
                w_busy = 1'b1;
                w_done = (r_gap_cnt == GAP_W'(GAP));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack     <= '0;
            r_fsm_rst <= 1'b1;
            r_bit_o   <= 1'b0;
            r_bit_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_ack     <= w_ack;
            r_fsm_rst <= w_fsm_rst;
            r_bit_o   <= w_bit_o;
            r_bit_vld <= w_bit_vld;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    assign bus.ack     = r_ack;
    assign bus.fsm_rst = r_fsm_rst;
    assign bus.bit_o   = r_bit_o;
    assign bus.bit_vld = r_bit_vld;
    assign bus.owner   = r_owner;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

endmodule

// File: tb/tb_fsm_stim_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fsm_stim_arbiter
// Two arbiters (GAP=1 and GAP=0) share one stimulus. A frame-level model
// predicts every output from the cycle offset since the last grant.
// ---------------------------------------------------------------------------
module tb_fsm_stim_arbiter;

    localparam int N = 2;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        tb_rst_n;
    logic [1:0]  tb_req;
    logic [15:0] tb_data;

    always #5 clk = ~clk;

    fsm_stim_arbiter_if #(.N_REQ(N), .W(W)) if_a ();
    fsm_stim_arbiter_if #(.N_REQ(N), .W(W)) if_b ();

    assign if_a.req  = tb_req;
    assign if_a.data = tb_data;
    assign if_b.req  = tb_req;
    assign if_b.data = tb_data;

    fsm_stim_arbiter #(.N_REQ(N), .W(W), .GAP(1)) dut_a (.clk(clk), .rst_n(tb_rst_n), .bus(if_a));
    fsm_stim_arbiter #(.N_REQ(N), .W(W), .GAP(0)) dut_b (.clk(clk), .rst_n(tb_rst_n), .bus(if_b));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // frame-level reference state, index 0 -> GAP=1 build, 1 -> GAP=0
    int         a_last [2];
    bit         a_val  [2];
    int         ptr_m  [2];
    int         own_m  [2];
    logic [W-1:0] frm  [2];
    logic [1:0] e_ack  [2];
    logic       e_rst  [2];
    logic       e_vld  [2];
    logic       e_bit  [2];
    logic       e_done [2];
    logic       e_busy [2];

    // Advance one clock, update the model with the inputs seen at the edge,
    // then settle #1 so outputs can be sampled.
    task automatic tick();
        logic [1:0]  rq;
        logic [15:0] dt;
        logic        rn;
        int g, d, k;
        rq = tb_req;
        dt = tb_data;
        rn = tb_rst_n;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            g = (i == 0) ? 1 : 0;
            if (!rn) begin
                a_val[i] = 1'b0; ptr_m[i] = 0; own_m[i] = 0;
                e_ack[i] = 2'b00; e_rst[i] = 1'b1; e_vld[i] = 1'b0;
                e_bit[i] = 1'b0; e_done[i] = 1'b0; e_busy[i] = 1'b0;
            end else begin
                e_ack[i] = 2'b00;
                if ((!a_val[i] || cyc >= a_last[i] + W + 3 + g) && rq != 2'b00) begin
                    k = -1;
                    for (int off = 0; off < N; off++)
                        if (k < 0 && rq[(ptr_m[i] + off) % N]) k = (ptr_m[i] + off) % N;
                    e_ack[i]  = 2'b01 << k;
                    a_last[i] = cyc;
                    a_val[i]  = 1'b1;
                    frm[i]    = dt[k*W +: W];
                    own_m[i]  = k;
                    ptr_m[i]  = (k + 1) % N;
                end
                d = a_val[i] ? cyc - a_last[i] : -1000;
                e_rst[i]  = (d == 1);
                e_vld[i]  = (d >= 2 && d <= W + 1);
                e_bit[i]  = e_vld[i] ? frm[i][W-1-(d-2)] : 1'b0;
                e_done[i] = (d == W + 2);
                e_busy[i] = (d >= 1 && d <= W + 2 + g);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        tb_rst_n = 1'b0;
        tb_req   = 2'b00;
        repeat (3) tick();
        tb_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tb_rst_n = 1'b0;
        tb_req   = 2'b00;
        tb_data  = 16'($urandom);
        for (int n = 0; n < 3; n++) begin
            tick();
            n_cmp++; if (if_a.fsm_rst !== 1'b1) begin n_err++; $display("FAIL rst_fsm_rst got=%b exp=1", if_a.fsm_rst); end
            n_cmp++; if (if_a.ack !== 2'b00)    begin n_err++; $display("FAIL rst_ack got=%b exp=00", if_a.ack); end
            n_cmp++; if (if_a.bit_vld !== 1'b0) begin n_err++; $display("FAIL rst_bit_vld got=%b exp=0", if_a.bit_vld); end
            n_cmp++; if (if_a.busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy got=%b exp=0", if_a.busy); end
            n_cmp++; if (if_a.done !== 1'b0)    begin n_err++; $display("FAIL rst_done got=%b exp=0", if_a.done); end
            n_cmp++; if (if_a.owner !== 1'b0)   begin n_err++; $display("FAIL rst_owner got=%b exp=0", if_a.owner); end
            n_cmp++; if (if_b.fsm_rst !== 1'b1) begin n_err++; $display("FAIL rst_b_fsm_rst got=%b exp=1", if_b.fsm_rst); end
        end
        tb_rst_n = 1'b1;
        tick();
        n_cmp++; if (if_a.fsm_rst !== 1'b0) begin n_err++; $display("FAIL rel_fsm_rst got=%b exp=0", if_a.fsm_rst); end
        n_cmp++; if (if_b.fsm_rst !== 1'b0) begin n_err++; $display("FAIL rel_b_fsm_rst got=%b exp=0", if_b.fsm_rst); end
        for (int n = 0; n < 3; n++) begin
            tick();
            n_cmp++; if (if_a.busy !== 1'b0 || if_a.ack !== 2'b00)
                begin n_err++; $display("FAIL idle_quiet busy=%b ack=%b exp=0/00", if_a.busy, if_a.ack); end
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] pat;
        bit got;
        pat     = 8'hB4;
        tb_req  = 2'b01;
        tb_data = {8'h00, pat};
        got = 0;
        for (int n = 0; n < 8 && !got; n++) begin
            tick();
            if (if_a.ack !== 2'b00) got = 1;
        end
        n_cmp++; if (!got || if_a.ack !== 2'b01) begin n_err++; $display("FAIL single_ack got=%b exp=01", if_a.ack); end
        tb_req = 2'b00;
        tick();
        n_cmp++; if (if_a.fsm_rst !== 1'b1 || if_a.ack !== 2'b00)
            begin n_err++; $display("FAIL single_frst fsm_rst=%b ack=%b exp=1/00", if_a.fsm_rst, if_a.ack); end
        for (int j = 7; j >= 0; j--) begin
            tick();
            n_cmp++; if (if_a.bit_vld !== 1'b1 || if_a.bit_o !== pat[j] || if_a.fsm_rst !== 1'b0)
                begin n_err++; $display("FAIL single_bit%0d vld=%b bit=%b exp=1/%b", j, if_a.bit_vld, if_a.bit_o, pat[j]); end
        end
        tick();
        n_cmp++; if (if_a.done !== 1'b1 || if_a.bit_vld !== 1'b0)
            begin n_err++; $display("FAIL single_done done=%b vld=%b exp=1/0", if_a.done, if_a.bit_vld); end
        tick();
        n_cmp++; if (if_a.done !== 1'b0 || if_a.busy !== 1'b1)
            begin n_err++; $display("FAIL single_gap done=%b busy=%b exp=0/1", if_a.done, if_a.busy); end
        tick();
        n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL single_idle busy=%b exp=0", if_a.busy); end
    endtask

    task automatic test_contention();
        logic [1:0] acks [3];
        int owns [3];
        int at [3];
        int na;
        do_reset();
        tb_req  = 2'b11;
        tb_data = {8'h00, 8'hFF};
        na = 0;
        for (int n = 0; n < 60 && na < 3; n++) begin
            tick();
            if (if_a.ack !== 2'b00) begin
                acks[na] = if_a.ack; owns[na] = int'(if_a.owner); at[na] = cyc; na++;
            end
            if (if_a.bit_vld === 1'b1) begin
                n_cmp++; if (if_a.bit_o !== (if_a.owner == 1'b0))
                    begin n_err++; $display("FAIL cont_bit owner=%0d got=%b", if_a.owner, if_a.bit_o); end
            end
        end
        tb_req = 2'b00;
        n_cmp++;
        if (na < 3) begin
            n_err++; $display("FAIL cont_count got=%0d exp=3", na);
        end else begin
            n_cmp++; if (acks[0] !== 2'b01 || acks[1] !== 2'b10 || acks[2] !== 2'b01)
                begin n_err++; $display("FAIL cont_order got=%b,%b,%b exp=01,10,01", acks[0], acks[1], acks[2]); end
            n_cmp++; if (owns[0] != 0 || owns[1] != 1 || owns[2] != 0)
                begin n_err++; $display("FAIL cont_owner got=%0d,%0d,%0d exp=0,1,0", owns[0], owns[1], owns[2]); end
            n_cmp++; if (at[1] - at[0] != 12 || at[2] - at[1] != 12)
                begin n_err++; $display("FAIL cont_period got=%0d,%0d exp=12,12", at[1]-at[0], at[2]-at[1]); end
        end
        repeat (14) tick();
    endtask

    task automatic test_late_request();
        int a0, ad, a1;
        bit got;
        do_reset();
        tb_req  = 2'b01;
        tb_data = 16'($urandom);
        got = 0; a0 = 0;
        for (int n = 0; n < 8 && !got; n++) begin
            tick();
            if (if_a.ack !== 2'b00) begin got = 1; a0 = cyc; end
        end
        tb_req = 2'b00;
        repeat (4) tick();
        tb_req = 2'b10;
        ad = -1; a1 = -1;
        for (int n = 0; n < 30 && a1 < 0; n++) begin
            tick();
            if (if_a.done === 1'b1) ad = cyc;
            if (if_a.ack !== 2'b00) begin
                a1 = cyc;
                n_cmp++; if (ad < 0 || if_a.ack !== 2'b10)
                    begin n_err++; $display("FAIL late_grant ack=%b done_seen=%0d exp=10 after done", if_a.ack, ad >= 0); end
            end
        end
        tb_req = 2'b00;
        n_cmp++; if (ad != a0 + 10) begin n_err++; $display("FAIL late_done_cyc got=%0d exp=%0d", ad, a0 + 10); end
        n_cmp++; if (a1 != a0 + 12) begin n_err++; $display("FAIL late_ack_cyc got=%0d exp=%0d", a1, a0 + 12); end
        repeat (14) tick();
    endtask

    task automatic test_reset_mid();
        int a0;
        bit got;
        do_reset();
        tb_req  = 2'b01;
        tb_data = 16'($urandom);
        got = 0; a0 = 0;
        for (int n = 0; n < 8 && !got; n++) begin
            tick();
            if (if_a.ack !== 2'b00) begin got = 1; a0 = cyc; end
        end
        tb_req = 2'b00;
        while (cyc < a0 + 4) tick();
        tb_rst_n = 1'b0;
        tick();
        n_cmp++; if (if_a.fsm_rst !== 1'b1 || if_a.bit_vld !== 1'b0)
            begin n_err++; $display("FAIL midrst_out fsm_rst=%b vld=%b exp=1/0", if_a.fsm_rst, if_a.bit_vld); end
        tb_rst_n = 1'b1;
        tb_req   = 2'b11;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            n_cmp++; if (if_a.done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b exp=0", if_a.done); end
            if (if_a.ack !== 2'b00) begin
                got = 1;
                n_cmp++; if (if_a.ack !== 2'b01) begin n_err++; $display("FAIL midrst_first got=%b exp=01", if_a.ack); end
            end
        end
        tb_req = 2'b00;
        n_cmp++; if (!got) begin n_err++; $display("FAIL midrst_nogrant got=0 exp=1"); end
        repeat (14) tick();
    endtask

    task automatic test_gap0();
        int acks [2];
        int dn;
        int na;
        do_reset();
        tb_req  = 2'b01;
        tb_data = 16'($urandom);
        na = 0; dn = -1;
        for (int n = 0; n < 40 && na < 2; n++) begin
            tick();
            if (if_b.done === 1'b1 && dn < 0) begin
                dn = cyc;
                n_cmp++; if (if_b.bit_vld !== 1'b0) begin n_err++; $display("FAIL gap0_vld_done got=%b exp=0", if_b.bit_vld); end
            end
            if (if_b.ack !== 2'b00) begin
                acks[na] = cyc; na++;
                n_cmp++; if (if_b.bit_vld !== 1'b0) begin n_err++; $display("FAIL gap0_vld_ack got=%b exp=0", if_b.bit_vld); end
            end
        end
        tb_req = 2'b00;
        n_cmp++;
        if (na < 2 || dn < 0) begin
            n_err++; $display("FAIL gap0_count acks=%0d done=%0d exp=2/seen", na, dn);
        end else begin
            n_cmp++; if (dn != acks[0] + 10) begin n_err++; $display("FAIL gap0_done_cyc got=%0d exp=%0d", dn, acks[0] + 10); end
            n_cmp++; if (acks[1] != dn + 1)  begin n_err++; $display("FAIL gap0_reack got=%0d exp=%0d", acks[1], dn + 1); end
        end
        repeat (14) tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 1200; n++) begin
            tb_rst_n = ($urandom_range(0, 249) != 0);
            tb_req   = 2'($urandom_range(0, 3));
            tb_data  = 16'($urandom);
            tick();
            n_cmp++; if (if_a.ack !== e_ack[0])     begin n_err++; $display("FAIL rnd_a_ack cyc=%0d got=%b exp=%b", cyc, if_a.ack, e_ack[0]); end
            n_cmp++; if (if_a.fsm_rst !== e_rst[0]) begin n_err++; $display("FAIL rnd_a_fsm_rst cyc=%0d got=%b exp=%b", cyc, if_a.fsm_rst, e_rst[0]); end
            n_cmp++; if (if_a.bit_vld !== e_vld[0]) begin n_err++; $display("FAIL rnd_a_vld cyc=%0d got=%b exp=%b", cyc, if_a.bit_vld, e_vld[0]); end
            n_cmp++; if (if_a.bit_o !== e_bit[0])   begin n_err++; $display("FAIL rnd_a_bit cyc=%0d got=%b exp=%b", cyc, if_a.bit_o, e_bit[0]); end
            n_cmp++; if (if_a.done !== e_done[0])   begin n_err++; $display("FAIL rnd_a_done cyc=%0d got=%b exp=%b", cyc, if_a.done, e_done[0]); end
            n_cmp++; if (if_a.busy !== e_busy[0])   begin n_err++; $display("FAIL rnd_a_busy cyc=%0d got=%b exp=%b", cyc, if_a.busy, e_busy[0]); end
            n_cmp++; if (if_a.owner !== 1'(own_m[0])) begin n_err++; $display("FAIL rnd_a_owner cyc=%0d got=%b exp=%0d", cyc, if_a.owner, own_m[0]); end
            n_cmp++; if (if_b.ack !== e_ack[1])     begin n_err++; $display("FAIL rnd_b_ack cyc=%0d got=%b exp=%b", cyc, if_b.ack, e_ack[1]); end
            n_cmp++; if (if_b.fsm_rst !== e_rst[1]) begin n_err++; $display("FAIL rnd_b_fsm_rst cyc=%0d got=%b exp=%b", cyc, if_b.fsm_rst, e_rst[1]); end
            n_cmp++; if (if_b.bit_vld !== e_vld[1]) begin n_err++; $display("FAIL rnd_b_vld cyc=%0d got=%b exp=%b", cyc, if_b.bit_vld, e_vld[1]); end
            n_cmp++; if (if_b.bit_o !== e_bit[1])   begin n_err++; $display("FAIL rnd_b_bit cyc=%0d got=%b exp=%b", cyc, if_b.bit_o, e_bit[1]); end
            n_cmp++; if (if_b.done !== e_done[1])   begin n_err++; $display("FAIL rnd_b_done cyc=%0d got=%b exp=%b", cyc, if_b.done, e_done[1]); end
            n_cmp++; if (if_b.busy !== e_busy[1])   begin n_err++; $display("FAIL rnd_b_busy cyc=%0d got=%b exp=%b", cyc, if_b.busy, e_busy[1]); end
            n_cmp++; if (if_b.owner !== 1'(own_m[1])) begin n_err++; $display("FAIL rnd_b_owner cyc=%0d got=%b exp=%0d", cyc, if_b.owner, own_m[1]); end
        end
    endtask

    initial begin
        tb_rst_n = 1'b0;
        tb_req   = 2'b00;
        tb_data  = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            a_last[i] = 0; a_val[i] = 1'b0; ptr_m[i] = 0; own_m[i] = 0; frm[i] = '0;
        end
        test_reset();
        test_single_frame();
        test_contention();
        test_late_request();
        test_reset_mid();
        test_gap0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fsm_stim_arbiter.md
Name: fsm_stim_arbiter

Overview:
- Round-robin scheduler that shares the single-bit serial input of a downstream FSM among N_REQ requesters.
- Each requester offers a W-bit frame. The block grants one requester at a time, pulses a reset into the downstream FSM, then serialises the frame MSB-first onto that FSM's input bit, one bit per clock.
- Sits between stimulus/command sources and the FSM: it drives the FSM's `rst` and `i`, and reports frame ownership and completion.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- W, 8, frame width in bits (2..32).
- GAP, 1, idle cycles after each frame before re-arbitration (0..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- req  input  N_REQ  per-requester frame request; level, held until ack.
- data  input  N_REQ*W  frames; requester k uses bits [k*W +: W]; sampled only in the ack cycle.
- ack  output  N_REQ  one-hot, one-cycle pulse: frame of requester k is loaded.
- fsm_rst  output  1  active-high synchronous reset to the downstream FSM.
- bit_o  output  1  serial bit to the downstream FSM input.
- bit_vld  output  1  bit_o carries a frame bit.
- owner  output  clog2(N_REQ)  index of the current or last granted requester.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last bit of a frame.

Behaviour:
- All outputs are registered.
- Reset values, while rst_n=0 at a clk edge:
  - state=IDLE, ack=0, bit_o=0, bit_vld=0, owner=0, busy=0, done=0.
  - fsm_rst=1, so the downstream FSM is held in reset.
  - Round-robin pointer ptr=0; shift register, bit counter and gap counter cleared.
- Reset mid-frame aborts the frame silently: no done pulse, no further ack.
- State IDLE:
  - fsm_rst=0.
  - If any req is set, grant the first set req found starting at ptr and wrapping modulo N_REQ. Call it k.
  - In the same registered update: ack[k]=1 for exactly one cycle, shift register <= data[k], owner<=k, ptr<=(k+1) mod N_REQ, next state FRST.
  - If no req is set, stay in IDLE.
- State FRST (1 cycle): fsm_rst=1, bit_vld=0, busy=1. Next state SHIFT.
- State SHIFT (exactly W cycles):
  - fsm_rst=0, bit_vld=1, bit_o = shift register MSB.
  - Shift left by 1 each cycle; the counter counts 0..W-1.
  - Frame bit j (MSB=bit W-1) is presented in SHIFT cycle W-1-j.
  - After the cycle with count W-1: done=1 for one cycle, and the next state is GAP (or IDLE if GAP=0).
- State GAP (GAP cycles): bit_vld=0, bit_o=0, busy=1. Next state IDLE.
- Latency: req sampled high in IDLE at edge t → ack high after edge t → fsm_rst high after t+1 → first bit_vld after t+2 → done high after t+2+W.
- Minimum frame-to-frame period: W+2+GAP+1 cycles (the +1 is the IDLE arbitration cycle).
- req changes:
  - A req rising while not IDLE waits for the next IDLE.
  - A req dropping before ack is simply not granted.
  - A req still high after its ack is treated as a new request.
- Simultaneous requests:
  - Only one ack per arbitration.
  - With N_REQ=2 and both requesting continuously, grants alternate 0,1,0,1.
- bit_o and bit_vld are 0 in every state other than SHIFT.

Decomposition:
- Shared package fsm_stim_pkg holds:
  - the state enumeration IDLE/FRST/SHIFT/GAP, 2 bits;
  - the clog2-based width constants for owner and the bit counter.
- One natural sub-module: rr_pick.
  - Combinational round-robin priority search: inputs req and ptr; outputs a valid flag and index k.
  - Reused by later arbiters.
- Everything else (shifter, counters, FSM) lives in fsm_stim_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles.
  - Required: fsm_rst=1, ack=0, bit_vld=0, busy=0, done=0.
  - Release reset: fsm_rst=0 after 1 cycle; the block stays IDLE with no req.
- Single frame: req[0]=1, data[0]=8'hB4.
  - Required: ack=2'b01 for 1 cycle; fsm_rst=1 for 1 cycle.
  - Then bit_o=1,0,1,1,0,1,0,0 with bit_vld=1 for 8 cycles.
  - Then done=1 for 1 cycle, 1 GAP cycle, busy=0.
- Contention: req=2'b11 held, data[0]=8'hFF, data[1]=8'h00.
  - Required: ack order 01,10,01.
  - owner sequence 0,1,0; frames all-ones, all-zeros, all-ones.
  - Each ack is exactly 12 cycles after the previous ack (W+2+GAP+1 = 8+2+1+1).
- Late request: raise req[1] in the middle of requester 0's SHIFT.
  - Required: no ack until IDLE; ack[1] is the first grant after done.
- Reset mid-frame: drop rst_n at SHIFT count 3.
  - Required: next cycle fsm_rst=1 and bit_vld=0; done never pulses; ptr=0, so a subsequent req=2'b11 grants requester 0 first.
- GAP=0 build with req[0] held.
  - Required: done, then IDLE for 1 cycle, then ack with no bit_vld cycle in between.
